// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a combinational N_IN-input function block through every
// input code, samples its output after SETTLE cycles per code, and builds the minterm
// map (bit i = f(i)). A one-cycle done pulse marks a complete sweep.
// Optional feature macro: SWEEP_CHECK_EN adds a comparison against an expected table.
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 f_in,
`ifdef SWEEP_CHECK_EN
    input  logic [2**N_IN-1:0]   expected,
    output logic                 match,
    output logic [N_IN:0]        mismatch_count,
`endif
    output logic [N_IN-1:0]      code,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   minterms
);

    localparam int MAP_W = 2**N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [MAP_W-1:0]  minterms_q, minterms_d;

`ifdef SWEEP_CHECK_EN
    logic              match_q, match_d;
    logic [N_IN:0]     mismatch_q, mismatch_d;

    // Number of set bits in a minterm-wide vector.
    function automatic logic [N_IN:0] popcount(input logic [MAP_W-1:0] v);
        logic [N_IN:0] acc;
        acc = '0;
        for (int i = 0; i < MAP_W; i++) begin
            acc = acc + {{N_IN{1'b0}}, v[i]};
        end
        return acc;
    endfunction
`endif

    // Next-state logic: sequence codes, hold each for SETTLE cycles, then capture f_in.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        minterms_d = minterms_q;
`ifdef SWEEP_CHECK_EN
        match_d    = match_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_DRIVE;
                    code_d     = '0;
                    cnt_d      = '0;
                    minterms_d = '0;
                    busy_d     = 1'b1;
`ifdef SWEEP_CHECK_EN
                    match_d    = 1'b0;
                    mismatch_d = '0;
`endif
                end
            end
            S_DRIVE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                minterms_d[code_q] = f_in;
                if (code_q == {N_IN{1'b1}}) begin
                    // Last code: keep it on the bus through the DONE cycle.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef SWEEP_CHECK_EN
                    match_d    = (minterms_d == expected);
                    mismatch_d = popcount(minterms_d ^ expected);
`endif
                end else begin
                    state_d = S_DRIVE;
                    code_d  = code_q + N_IN'(1);
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                code_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any sweep and clears the captured table.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            minterms_q <= '0;
`ifdef SWEEP_CHECK_EN
            match_q    <= 1'b0;
            mismatch_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            minterms_q <= minterms_d;
`ifdef SWEEP_CHECK_EN
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign code     = code_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign minterms = minterms_q;
`ifdef SWEEP_CHECK_EN
    assign match          = match_q;
    assign mismatch_count = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps of a table-driven function block, with a
// cycle-count model of the sweep timing and the resulting truth table.
module tb_truth_table_sweeper;

    localparam int N_IN   = 4;
    localparam int SETTLE = 1;
    localparam int MAP_W  = 16;
    localparam int PER    = SETTLE + 1;
    localparam int SWEEP  = MAP_W * PER;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        f_in;
    logic [3:0]  code;
    logic        busy;
    logic        done;
    logic [15:0] minterms;
    logic [15:0] expected_v;
`ifdef SWEEP_CHECK_EN
    logic        match;
    logic [4:0]  mismatch_count;
`endif

    int          total = 0;
    int          bad   = 0;
    int          mode  = 0;
    logic [15:0] tbl   = 16'h61A3;
    logic        chk_en = 1'b0;

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .f_in           (f_in),
`ifdef SWEEP_CHECK_EN
        .expected       (expected_v),
        .match          (match),
        .mismatch_count (mismatch_count),
`endif
        .code           (code),
        .busy           (busy),
        .done           (done),
        .minterms       (minterms)
    );

    always #5 clock = ~clock;

    // Function block under sweep: mode 0 = prob_4_47_a table, 1 = const 1, 2 = const 0.
    function automatic logic func_of(input int md, input int i);
        if (md == 0) return tbl[i];
        return (md == 1);
    endfunction

    function automatic logic [15:0] table_of(input int md);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < MAP_W; i++) t[i] = func_of(md, i);
        return t;
    endfunction

    assign f_in = func_of(mode, int'(code));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a sweep is SWEEP cycles long from accept; code = elapsed/PER; then one DONE cycle.
    logic        e_active = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_match = 1'b0;
    logic [3:0]  e_code = '0;
    logic [15:0] e_min = '0;
    int          e_mm = 0;
    int          k = 0;

    always @(posedge clock) begin
        if (reset) begin
            e_active <= 1'b0; e_done <= 1'b0; e_busy <= 1'b0;
            e_code <= '0; e_min <= '0; e_match <= 1'b0; e_mm <= 0; k <= 0;
        end else if (e_done) begin
            e_done <= 1'b0;
            e_code <= '0;
        end else if (e_active) begin
            k <= k + 1;
            if (k + 1 == SWEEP) begin
                e_done   <= 1'b1;
                e_busy   <= 1'b0;
                e_active <= 1'b0;
                e_min    <= table_of(mode);
                e_match  <= (table_of(mode) == expected_v);
                e_mm     <= $countones(table_of(mode) ^ expected_v);
            end else begin
                e_code <= 4'((k + 1) / PER);
            end
        end else if (start) begin
            e_active <= 1'b1; e_busy <= 1'b1; k <= 0;
            e_code <= '0; e_min <= '0; e_match <= 1'b0; e_mm <= 0;
        end
    end

    // Every-cycle comparison against the model, on the inactive edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("code", 32'(code), 32'(e_code));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            if (!e_busy) chk("minterms_model", 32'(minterms), 32'(e_min));
`ifdef SWEEP_CHECK_EN
            if (!e_busy) begin
                chk("match_model", 32'(match), 32'(e_match));
                chk("mismatch_model", 32'(mismatch_count), 32'(e_mm));
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_sweep(input int md, input logic [15:0] want);
        int n;
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(n);
        chk("latency", 32'(n), 32'd32);
        chk("minterms_lit", 32'(minterms), 32'(want));
        tick();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        expected_v = 16'h61A3;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_minterms", 32'(minterms), 32'h0000);
        reset = 1'b0;
        tick();

        // prob_4_47_a, then constant functions overwriting it
        run_sweep(0, 16'h61A3);
        run_sweep(1, 16'hFFFF);
        run_sweep(2, 16'h0000);

        // start held through the sweep and the DONE cycle
        mode  = 0;
        start = 1'b1;
        tick();
        wait_done(n);
        chk("held_latency", 32'(n), 32'd32);
        tick();
        start = 1'b0;
        chk("no_restart_busy", 32'(busy), 32'd0);
        tick();
        chk("no_restart_idle", 32'(busy), 32'd0);
        chk("no_second_done", 32'(done), 32'd0);
        run_sweep(0, 16'h61A3);

        // abort at code 7
        mode  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (code != 4'd7 && n < 100) begin
            tick();
            n++;
        end
        chk("reach_code7", 32'(code), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_code", 32'(code), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_minterms", 32'(minterms), 32'h0000);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end

`ifdef SWEEP_CHECK_EN
        expected_v = 16'h61A3;
        run_sweep(0, 16'h61A3);
        chk("match_exact", 32'(match), 32'd1);
        chk("mm_exact", 32'(mismatch_count), 32'd0);
        expected_v = 16'h61A2;
        run_sweep(0, 16'h61A3);
        chk("match_off1", 32'(match), 32'd0);
        chk("mm_off1", 32'(mismatch_count), 32'd1);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
